// File: rtl/req_ack_done_pkg.sv
// Shared types, parameter limits and the round-robin search used by the
// multi-channel req/ack/done responder and its arbiter.
package req_ack_done_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_ACK = 2'd1,
      XFR      = 2'd2,
      RELEASE  = 2'd3
   } state_t;

   localparam int NCH_MIN     = 2;
   localparam int NCH_MAX     = 16;
   localparam int ACK_DLY_MIN = 1;
   localparam int ACK_DLY_MAX = 15;
   localparam int TMO_MIN     = 2;
   localparam int TMO_MAX     = 255;
   localparam int LAT_W       = 4;
   localparam int TMO_W       = 8;

   typedef struct packed {
      logic       valid;
      logic [3:0] idx;
   } rr_pick_t;

   // First requesting channel at or after ptr, wrapping modulo nch (ptr < nch).
   function automatic rr_pick_t rr_search(input logic [NCH_MAX-1:0] req,
                                          input logic [3:0]         ptr,
                                          input int                 nch);
      rr_pick_t   pick;
      logic [4:0] cand;
      pick = '0;
      for (int i = 0; i < NCH_MAX; i++) begin
         cand = {1'b0, ptr} + 5'(i);
         cand = (cand >= 5'(nch)) ? (cand - 5'(nch)) : cand;
         if (!pick.valid && (i < nch) && req[cand[3:0]]) begin
            pick.valid = 1'b1;
            pick.idx   = cand[3:0];
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/req_ack_done_mc_rr_arbiter.sv
// Combinational round-robin arbiter: request vector plus priority pointer in,
// one-hot grant and binary index out.
module rr_arbiter
   import req_ack_done_pkg::*;
#(
   parameter int NCH = 4,
   parameter int IW  = $clog2(NCH)
) (
   input  logic [NCH-1:0] req,
   input  logic [IW-1:0]  ptr,
   output logic [NCH-1:0] gnt,
   output logic [IW-1:0]  idx,
   output logic           valid
);

   localparam logic [NCH-1:0] CH0_MASK = {{(NCH-1){1'b0}}, 1'b1};

   rr_pick_t           pick_s;
   logic [NCH_MAX-1:0] req_ext_s;

   // Widen to the package search width and turn the pick into grant outputs.
   always_comb begin
      req_ext_s          = '0;
      req_ext_s[NCH-1:0] = req;
      pick_s             = rr_search(req_ext_s, 4'(ptr), NCH);
      valid              = pick_s.valid && ({1'b0, pick_s.idx} < 5'(NCH));
      idx                = IW'(pick_s.idx);
      if (valid) begin
         gnt = CH0_MASK << idx;
      end else begin
         gnt = '0;
      end
   end

endmodule

// File: rtl/req_ack_done_mc.sv
// Multi-channel req/ack/done responder: round-robin grant, programmable ack
// latency, done timeout with error report, abort and completed-transfer count.
module req_ack_done_mc
   import req_ack_done_pkg::*;
#(
   parameter int NCH     = 4,
   parameter int ACK_DLY = 2,
   parameter int TMO     = 16,
   parameter int CNTW    = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NCH-1:0]           req,
   input  logic [NCH-1:0]           done_xfr,
   output logic [NCH-1:0]           ack,
   output logic                     busy,
   output logic [$clog2(NCH)-1:0]   cur_ch,
   output logic                     err_tmo,
   output logic [$clog2(NCH)-1:0]   err_ch,
   output logic [CNTW-1:0]          xfr_cnt
);

   localparam int             IW       = $clog2(NCH);
   localparam logic [NCH-1:0] CH0_MASK = {{(NCH-1){1'b0}}, 1'b1};
   localparam logic [IW-1:0]  LAST_CH  = IW'(NCH - 1);
   localparam logic [IW-1:0]  IDX_ONE  = IW'(1'b1);
   localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1'b1);

   state_t            state_r,   state_nxt_s;
   logic [LAT_W-1:0]  lat_r,     lat_nxt_s;
   logic [TMO_W-1:0]  tmo_r,     tmo_nxt_s;
   logic [IW-1:0]     rr_ptr_r,  rr_ptr_nxt_s;
   logic [IW-1:0]     cur_ch_r,  cur_ch_nxt_s;
   logic [IW-1:0]     err_ch_r,  err_ch_nxt_s;
   logic [NCH-1:0]    ack_r,     ack_nxt_s;
   logic              err_tmo_r, err_tmo_nxt_s;
   logic              busy_r;
   logic [CNTW-1:0]   cnt_r,     cnt_nxt_s;

   logic [NCH-1:0]    gnt_s;
   logic [IW-1:0]     gnt_idx_s;
   logic              gnt_valid_s;

   rr_arbiter #(
      .NCH (NCH),
      .IW  (IW)
   ) u_arb (
      .req   (req),
      .ptr   (rr_ptr_r),
      .gnt   (gnt_s),
      .idx   (gnt_idx_s),
      .valid (gnt_valid_s)
   );

   // Next-state and next-output logic; every output is registered below.
   always_comb begin
      state_nxt_s   = state_r;
      lat_nxt_s     = lat_r;
      tmo_nxt_s     = tmo_r;
      rr_ptr_nxt_s  = rr_ptr_r;
      cur_ch_nxt_s  = cur_ch_r;
      err_ch_nxt_s  = err_ch_r;
      ack_nxt_s     = ack_r;
      err_tmo_nxt_s = 1'b0;
      cnt_nxt_s     = cnt_r;
      case (state_r)
         IDLE: begin
            if (gnt_valid_s) begin
               cur_ch_nxt_s = gnt_idx_s;
               rr_ptr_nxt_s = (gnt_idx_s == LAST_CH) ? '0 : (gnt_idx_s + IDX_ONE);
               // With a one-cycle latency the ack register loads on the grant edge.
               if (ACK_DLY == 32'sd1) begin
                  ack_nxt_s   = gnt_s;
                  tmo_nxt_s   = 8'd1;
                  state_nxt_s = XFR;
               end else begin
                  lat_nxt_s   = LAT_W'(ACK_DLY - 1);
                  state_nxt_s = WAIT_ACK;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         WAIT_ACK: begin
            if (!req[cur_ch_r]) begin
               state_nxt_s = IDLE;
            end else if (lat_r == 4'd1) begin
               ack_nxt_s   = CH0_MASK << cur_ch_r;
               tmo_nxt_s   = 8'd1;
               state_nxt_s = XFR;
            end else begin
               lat_nxt_s   = lat_r - 4'd1;
            end
         end
         XFR: begin
            if (done_xfr[cur_ch_r]) begin
               ack_nxt_s   = '0;
               cnt_nxt_s   = cnt_r + CNT_ONE;
               state_nxt_s = RELEASE;
            end else if (tmo_r == TMO_W'(TMO)) begin
               ack_nxt_s     = '0;
               err_tmo_nxt_s = 1'b1;
               err_ch_nxt_s  = cur_ch_r;
               state_nxt_s   = RELEASE;
            end else begin
               tmo_nxt_s = tmo_r + 8'd1;
            end
         end
         RELEASE: begin
            if (!req[cur_ch_r]) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = RELEASE;
            end
         end
         default: begin
            ack_nxt_s   = '0;
            state_nxt_s = IDLE;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         lat_r     <= '0;
         tmo_r     <= '0;
         rr_ptr_r  <= '0;
         cur_ch_r  <= '0;
         err_ch_r  <= '0;
         ack_r     <= '0;
         err_tmo_r <= 1'b0;
         busy_r    <= 1'b0;
         cnt_r     <= '0;
      end else begin
         state_r   <= state_nxt_s;
         lat_r     <= lat_nxt_s;
         tmo_r     <= tmo_nxt_s;
         rr_ptr_r  <= rr_ptr_nxt_s;
         cur_ch_r  <= cur_ch_nxt_s;
         err_ch_r  <= err_ch_nxt_s;
         ack_r     <= ack_nxt_s;
         err_tmo_r <= err_tmo_nxt_s;
         busy_r    <= (state_nxt_s != IDLE);
         cnt_r     <= cnt_nxt_s;
      end
   end

   assign ack     = ack_r;
   assign busy    = busy_r;
   assign cur_ch  = cur_ch_r;
   assign err_tmo = err_tmo_r;
   assign err_ch  = err_ch_r;
   assign xfr_cnt = cnt_r;

endmodule
